// File: rtl/ternary_tree_driver_if.sv
// Operand and result streams between a serial source/sink and the tree driver.
// Optional TREE_DRV_OVF_EN adds the RES_OVF result flag.
interface ternary_tree_driver_if #(
    parameter int unsigned WIDTH = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic             RES_VALID;
    logic             RES_READY;
    logic [WIDTH-1:0] RES_DATA;
`ifdef TREE_DRV_OVF_EN
    logic             RES_OVF;

    modport master (
        output IN_VALID, IN_DATA, RES_READY,
        input  IN_READY, RES_VALID, RES_DATA, RES_OVF
    );
    modport slave (
        input  IN_VALID, IN_DATA, RES_READY,
        output IN_READY, RES_VALID, RES_DATA, RES_OVF
    );
`else
    modport master (
        output IN_VALID, IN_DATA, RES_READY,
        input  IN_READY, RES_VALID, RES_DATA
    );
    modport slave (
        input  IN_VALID, IN_DATA, RES_READY,
        output IN_READY, RES_VALID, RES_DATA
    );
`endif
endinterface

// File: rtl/ternary_tree_driver.sv
// Operand-side controller for the five-input ternary adder tree: loads five operands serially,
// holds them on A..E, waits out the tree latency and returns the captured sum.
// Optional macro TREE_DRV_OVF_EN adds RES_OVF, flagging a true sum above 2^WIDTH-1.
module ternary_tree_driver #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned TREE_LATENCY = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    ternary_tree_driver_if.slave   bus,
    output logic [WIDTH-1:0]       A,
    output logic [WIDTH-1:0]       B,
    output logic [WIDTH-1:0]       C,
    output logic [WIDTH-1:0]       D,
    output logic [WIDTH-1:0]       E,
    input  logic [WIDTH-1:0]       SUM_IN
);

    typedef enum logic [1:0] {StLoad, StWait, StDone} state_e;

    state_e           state_q;
    logic [2:0]       idx_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] slot_q [5];
    logic             in_ready_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             accept;
`ifdef TREE_DRV_OVF_EN
    // Three guard bits hold the full five-operand sum.
    logic [WIDTH+2:0] acc_q;
    logic             res_ovf_q;
`endif

    assign accept = bus.IN_VALID && in_ready_q;

    // Load / wait / done sequencing with all outputs registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StLoad;
            idx_q       <= 3'd0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            for (int i = 0; i < 5; i++) slot_q[i] <= '0;
`ifdef TREE_DRV_OVF_EN
            acc_q       <= '0;
            res_ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        slot_q[idx_q] <= bus.IN_DATA;
`ifdef TREE_DRV_OVF_EN
                        acc_q <= acc_q + (WIDTH+3)'(bus.IN_DATA);
`endif
                        if (idx_q == 3'd4) begin
                            idx_q      <= 3'd0;
                            cnt_q      <= 4'(TREE_LATENCY);
                            in_ready_q <= 1'b0;
                            state_q    <= StWait;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        // Covers the first edge after reset release.
                        in_ready_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        res_data_q  <= SUM_IN;
                        res_valid_q <= 1'b1;
`ifdef TREE_DRV_OVF_EN
                        res_ovf_q   <= |acc_q[WIDTH+2:WIDTH];
`endif
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.RES_READY) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StLoad;
`ifdef TREE_DRV_OVF_EN
                        res_ovf_q   <= 1'b0;
                        acc_q       <= '0;
`endif
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign A             = slot_q[0];
    assign B             = slot_q[1];
    assign C             = slot_q[2];
    assign D             = slot_q[3];
    assign E             = slot_q[4];
    assign bus.IN_READY  = in_ready_q;
    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_DATA  = res_data_q;
`ifdef TREE_DRV_OVF_EN
    assign bus.RES_OVF   = res_ovf_q;
`endif

endmodule

// File: tb/tb_ternary_tree_driver.sv
// Directed bench for ternary_tree_driver: three instances with tree latency 0, 1 and 3,
// each fed by a behavioural tree model; one instance is selected at a time.
module tb_ternary_tree_driver;

    localparam int W = 16;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    ternary_tree_driver_if #(.WIDTH(W)) bus0 ();
    ternary_tree_driver_if #(.WIDTH(W)) bus1 ();
    ternary_tree_driver_if #(.WIDTH(W)) bus3 ();

    logic [4:0][W-1:0] op0, op1, op3;
    logic [W-1:0]      sum0, sum1, s3a, s3b, s3c;

    int unsigned sel = 1;
    logic         tb_valid = 1'b0;
    logic         tb_rready = 1'b0;
    logic [W-1:0] tb_data = '0;

    assign bus0.IN_VALID  = tb_valid && (sel == 0);
    assign bus1.IN_VALID  = tb_valid && (sel == 1);
    assign bus3.IN_VALID  = tb_valid && (sel == 3);
    assign bus0.IN_DATA   = tb_data;
    assign bus1.IN_DATA   = tb_data;
    assign bus3.IN_DATA   = tb_data;
    assign bus0.RES_READY = tb_rready && (sel == 0);
    assign bus1.RES_READY = tb_rready && (sel == 1);
    assign bus3.RES_READY = tb_rready && (sel == 3);

    function automatic logic [W-1:0] sum5(input logic [4:0][W-1:0] o);
        return o[0] + o[1] + o[2] + o[3] + o[4];
    endfunction

    // Tree models: combinational, one stage, three stages.
    assign sum0 = sum5(op0);
    always_ff @(posedge CLK) begin
        sum1 <= sum5(op1);
        s3a  <= sum5(op3);
        s3b  <= s3a;
        s3c  <= s3b;
    end

    ternary_tree_driver #(.WIDTH(W), .TREE_LATENCY(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus0),
        .A(op0[0]), .B(op0[1]), .C(op0[2]), .D(op0[3]), .E(op0[4]), .SUM_IN(sum0)
    );
    ternary_tree_driver #(.WIDTH(W), .TREE_LATENCY(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus1),
        .A(op1[0]), .B(op1[1]), .C(op1[2]), .D(op1[3]), .E(op1[4]), .SUM_IN(sum1)
    );
    ternary_tree_driver #(.WIDTH(W), .TREE_LATENCY(3)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus3),
        .A(op3[0]), .B(op3[1]), .C(op3[2]), .D(op3[3]), .E(op3[4]), .SUM_IN(s3c)
    );

    logic              cur_ready, cur_valid;
    logic [W-1:0]      cur_data;
    logic [4:0][W-1:0] cur_ops;
`ifdef TREE_DRV_OVF_EN
    logic              cur_ovf;
`endif

    // View of the currently selected instance.
    always_comb begin
        cur_ready = bus1.IN_READY;
        cur_valid = bus1.RES_VALID;
        cur_data  = bus1.RES_DATA;
        cur_ops   = op1;
`ifdef TREE_DRV_OVF_EN
        cur_ovf   = bus1.RES_OVF;
`endif
        if (sel == 0) begin
            cur_ready = bus0.IN_READY;
            cur_valid = bus0.RES_VALID;
            cur_data  = bus0.RES_DATA;
            cur_ops   = op0;
`ifdef TREE_DRV_OVF_EN
            cur_ovf   = bus0.RES_OVF;
`endif
        end else if (sel == 3) begin
            cur_ready = bus3.IN_READY;
            cur_valid = bus3.RES_VALID;
            cur_data  = bus3.RES_DATA;
            cur_ops   = op3;
`ifdef TREE_DRV_OVF_EN
            cur_ovf   = bus3.RES_OVF;
`endif
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0][W-1:0] ops;
        logic [W-1:0]      sum;
        logic              ovf;
    } vec_t;

    function automatic vec_t mk(input logic [W-1:0] a, b, c, d, e, input logic [W-1:0] s,
                                input logic ovf);
        vec_t v;
        v.ops[0] = a; v.ops[1] = b; v.ops[2] = c; v.ops[3] = d; v.ops[4] = e;
        v.sum = s;
        v.ovf = ovf;
        return v;
    endfunction

    // Presents one beat at a negedge; the following posedge accepts it.
    task automatic send_beat(input logic [W-1:0] d);
        int n = 0;
        while (!cur_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("in_ready_before_beat", {79'd0, cur_ready}, 80'd1);
        tb_valid = 1'b1;
        tb_data  = d;
        @(negedge CLK);
        tb_valid = 1'b0;
        tb_data  = 16'hDEAD;
    endtask

    task automatic wait_result(output int c);
        c = 0;
        while (!cur_valid && c < 40) begin
            @(negedge CLK);
            c++;
        end
    endtask

    // Back-to-back load with RES_READY already high.
    task automatic run_txn(input string name, input vec_t v);
        int c;
        tb_rready = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(v.ops[i]);
        check({name, "_ops"}, 80'(cur_ops), 80'(v.ops));
        check({name, "_in_ready_low"}, {79'd0, cur_ready}, 80'd0);
        wait_result(c);
        check({name, "_latency"}, 80'(c), 80'(sel + 1));
        check({name, "_res_data"}, 80'(cur_data), 80'(v.sum));
`ifdef TREE_DRV_OVF_EN
        check({name, "_res_ovf"}, {79'd0, cur_ovf}, {79'd0, v.ovf});
`endif
        check({name, "_no_overlap"}, {79'd0, cur_ready}, 80'd0);
        @(negedge CLK);
        check({name, "_valid_cleared"}, {79'd0, cur_valid}, 80'd0);
        check({name, "_in_ready_back"}, {79'd0, cur_ready}, 80'd1);
    endtask

    vec_t vecs[5];
    vec_t vstall, vrst, vlat3;
    int   gaps[5];
    int   c;

    initial begin
        vecs[0] = mk(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'h000F, 1'b0);
        vecs[1] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFB, 1'b1);
        vecs[2] = mk(16'h3333, 16'h3333, 16'h3333, 16'h3333, 16'h3333, 16'hFFFF, 1'b0);
        vecs[3] = mk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 1'b0);
        vecs[4] = mk(16'h8000, 16'h8000, 16'h0, 16'h0, 16'h1, 16'h0001, 1'b1);
        vstall  = mk(16'h1111, 16'h2222, 16'h0003, 16'h4000, 16'h0005, 16'h733B, 1'b0);
        vrst    = mk(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd150, 1'b0);
        vlat3   = mk(16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'h05DC, 1'b0);
        gaps    = '{0, 2, 0, 4, 0};

        // Reset state.
        #12;
        check("rst_ops", 80'(op1), 80'd0);
        check("rst_in_ready", {79'd0, bus1.IN_READY}, 80'd0);
        check("rst_res_valid", {79'd0, bus1.RES_VALID}, 80'd0);
        check("rst_res_data", 80'(bus1.RES_DATA), 80'd0);
`ifdef TREE_DRV_OVF_EN
        check("rst_res_ovf", {79'd0, bus1.RES_OVF}, 80'd0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("in_ready_after_release", {79'd0, bus1.IN_READY}, 80'd1);

        // Table-driven transactions on the latency-1 instance.
        sel = 1;
        for (int i = 0; i < 5; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Gapped loading, then a six-cycle result stall with IN_VALID toggling.
        tb_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (gaps[i]) begin
                tb_data = 16'hBEEF;
                @(negedge CLK);
            end
            send_beat(vstall.ops[i]);
        end
        check("stall_ops", 80'(cur_ops), 80'(vstall.ops));
        wait_result(c);
        check("stall_latency", 80'(c), 80'd2);
        for (int k = 0; k < 6; k++) begin
            tb_valid = ~tb_valid;
            tb_data  = 16'(16'hA5A5 + k);
            @(negedge CLK);
            check("stall_res_valid", {79'd0, cur_valid}, 80'd1);
            check("stall_res_data", 80'(cur_data), 80'(vstall.sum));
            check("stall_ops_held", 80'(cur_ops), 80'(vstall.ops));
            check("stall_in_ready", {79'd0, cur_ready}, 80'd0);
        end
        tb_valid  = 1'b0;
        tb_rready = 1'b1;
        @(negedge CLK);
        check("stall_release_valid", {79'd0, cur_valid}, 80'd0);
        check("stall_release_ready", {79'd0, cur_ready}, 80'd1);

        // Reset after three beats discards the partial load.
        send_beat(16'd7);
        send_beat(16'd8);
        send_beat(16'd9);
        RST_N = 1'b0;
        #1;
        check("midrst_ops", 80'(cur_ops), 80'd0);
        check("midrst_in_ready", {79'd0, cur_ready}, 80'd0);
        check("midrst_res_valid", {79'd0, cur_valid}, 80'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_txn("after_rst", vrst);

        // Latency 0 and latency 3 instances.
        sel = 0;
        run_txn("lat0", vecs[0]);
        sel = 3;
        run_txn("lat3", vlat3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
